// File: rtl/conv_pkg.sv
// Shared types and helpers for the sliding-window convolution engine.
package conv_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    MAC   = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4
  } state_e;

  // Number of full windows along one side of the image.
  function automatic int out_size(input int img, input int ker, input int stride);
    return (img - ker) / stride + 1;
  endfunction

  // Index width that exactly addresses an array of n entries (at least 1 bit).
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Clamp a sign-extended value into the signed range of out_w bits.
  function automatic logic signed [63:0] saturate(input logic signed [63:0] value,
                                                  input int out_w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (value > hi)      return hi;
    else if (value < lo) return lo;
    else                 return value;
  endfunction

endpackage

// File: rtl/conv_window_counter.sv
// Nested window (wr,wc) and tap (kr,kc) index counters for the window engine.
module conv_window_counter #(
  parameter int KER_SIZE = 3,
  parameter int OUT_SIZE = 5,
  parameter int WIN_W    = 4,
  parameter int TAP_W    = 2
) (
  input  logic             clock,
  input  logic             nreset,
  input  logic             win_clear_i,
  input  logic             win_advance_i,
  input  logic             tap_clear_i,
  input  logic             tap_advance_i,
  output logic [WIN_W-1:0] wr_o,
  output logic [WIN_W-1:0] wc_o,
  output logic [TAP_W-1:0] kr_o,
  output logic [TAP_W-1:0] kc_o,
  output logic             last_tap_o,
  output logic             last_win_o
);

  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(OUT_SIZE - 1);
  localparam logic [TAP_W-1:0] TAP_LAST = TAP_W'(KER_SIZE - 1);

  logic [WIN_W-1:0] wr_q, wr_d, wc_q, wc_d;
  logic [TAP_W-1:0] kr_q, kr_d, kc_q, kc_d;

  // Next-state: column counters wrap into their row counters.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    wr_d = wr_q;
    wc_d = wc_q;
    kr_d = kr_q;
    kc_d = kc_q;
    if (win_clear_i) begin
      wr_d = '0;
      wc_d = '0;
    end else if (win_advance_i) begin
      if (wc_q == WIN_LAST) begin
        wc_d = '0;
        wr_d = (wr_q == WIN_LAST) ? '0 : wr_q + WIN_W'(1);
      end else begin
        wc_d = wc_q + WIN_W'(1);
      end
    end
    if (tap_clear_i) begin
      kr_d = '0;
      kc_d = '0;
    end else if (tap_advance_i) begin
      if (kc_q == TAP_LAST) begin
        kc_d = '0;
        kr_d = (kr_q == TAP_LAST) ? '0 : kr_q + TAP_W'(1);
      end else begin
        kc_d = kc_q + TAP_W'(1);
      end
    end
  end

  // Counter state registers.
  always_ff @(posedge clock or negedge nreset) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!nreset) begin
      wr_q <= '0;
      wc_q <= '0;
      kr_q <= '0;
      kc_q <= '0;
    end else begin
      wr_q <= wr_d;
      wc_q <= wc_d;
      kr_q <= kr_d;
      kc_q <= kc_d;
    end
  end

  assign wr_o       = wr_q;
  assign wc_o       = wc_q;
  assign kr_o       = kr_q;
  assign kc_o       = kc_q;
  assign last_tap_o = (kr_q == TAP_LAST) && (kc_q == TAP_LAST);
  assign last_win_o = (wr_q == WIN_LAST) && (wc_q == WIN_LAST);

endmodule

// File: rtl/conv2d_window_engine.sv
// Sliding-window 2D convolution: one MAC per cycle, saturated registered results.
module conv2d_window_engine
  import conv_pkg::*;
#(
  parameter int  IMG_SIZE  = 7,
  parameter int  KER_SIZE  = 3,
  parameter int  STRIDE    = 1,
  parameter int  WIDTH_BIT = 8,
  parameter int  ACC_W     = 2 * WIDTH_BIT + 8,
  localparam int OUT_SIZE  = out_size(IMG_SIZE, KER_SIZE, STRIDE),
  localparam int IDX_W     = $clog2(OUT_SIZE) + 1
) (
  input  logic                        clock,
  input  logic                        nreset,
  input  logic                        start,
  input  logic signed [WIDTH_BIT-1:0] inpMatrixI [IMG_SIZE][IMG_SIZE],
  input  logic signed [WIDTH_BIT-1:0] kernel [KER_SIZE][KER_SIZE],
  output logic                        busy,
  output logic                        done,
  output logic                        out_valid,
  output logic [IDX_W-1:0]            out_row,
  output logic [IDX_W-1:0]            out_col,
  output logic signed [WIDTH_BIT-1:0] out_data,
  output logic signed [WIDTH_BIT-1:0] convOut [OUT_SIZE][OUT_SIZE]
);

  localparam int OUT_IW = idx_w(OUT_SIZE);
  localparam int IMG_IW = idx_w(IMG_SIZE);
  localparam int KER_IW = idx_w(KER_SIZE);

  state_e state_q, state_d;

  logic [IDX_W-1:0]  wr, wc;
  logic [KER_IW-1:0] kr, kc;
  logic              last_tap, last_win;

  logic [IMG_IW-1:0]            row_idx, col_idx;
  logic signed [2*WIDTH_BIT-1:0] prod;
  logic signed [WIDTH_BIT-1:0]  sat;

  logic signed [ACC_W-1:0]     acc_q;
  logic                        busy_q, done_q, out_valid_q;
  logic [IDX_W-1:0]            out_row_q, out_col_q;
  logic signed [WIDTH_BIT-1:0] out_data_q;
  logic signed [WIDTH_BIT-1:0] conv_q [OUT_SIZE][OUT_SIZE];

  conv_window_counter #(
    .KER_SIZE (KER_SIZE),
    .OUT_SIZE (OUT_SIZE),
    .WIN_W    (IDX_W),
    .TAP_W    (KER_IW)
  ) u_counter (
    .clock         (clock),
    .nreset        (nreset),
    .win_clear_i   ((state_q == IDLE) && start),
    .win_advance_i (state_q == WRITE),
    .tap_clear_i   (state_q == CLEAR),
    .tap_advance_i (state_q == MAC),
    .wr_o          (wr),
    .wc_o          (wc),
    .kr_o          (kr),
    .kc_o          (kc),
    .last_tap_o    (last_tap),
    .last_win_o    (last_win)
  );

  // Sequencing: one clear, K*K MACs and one write per window, then a done cycle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = CLEAR;
      CLEAR:   state_d = MAC;
      MAC:     if (last_tap) state_d = WRITE;
      WRITE:   state_d = last_win ? DONE : CLEAR;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Current tap product and saturated accumulator value.
  always_comb begin
    row_idx = IMG_IW'(int'(wr) * STRIDE + int'(kr));
    col_idx = IMG_IW'(int'(wc) * STRIDE + int'(kc));
    prod    = (2*WIDTH_BIT)'(inpMatrixI[row_idx][col_idx]) * (2*WIDTH_BIT)'(kernel[kr][kc]);
    sat     = WIDTH_BIT'(saturate(64'(acc_q), WIDTH_BIT));
  end

  // Control, accumulator and result registers.
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_row_q   <= '0;
      out_col_q   <= '0;
      out_data_q  <= '0;
      // NOTE: the result matrix is a flop array visible on a port, so it is reset like any register.
      for (int r = 0; r < OUT_SIZE; r++)
        for (int c = 0; c < OUT_SIZE; c++)
          conv_q[r][c] <= '0;
    end else begin
      state_q     <= state_d;
      done_q      <= (state_q == DONE);
      out_valid_q <= (state_q == WRITE);
      if ((state_q == IDLE) && start) busy_q <= 1'b1;
      else if (state_q == DONE)       busy_q <= 1'b0;
      if (state_q == CLEAR)    acc_q <= '0;
      else if (state_q == MAC) acc_q <= acc_q + ACC_W'(prod);
      if (state_q == WRITE) begin
        conv_q[wr[OUT_IW-1:0]][wc[OUT_IW-1:0]] <= sat;
        out_data_q <= sat;
        out_row_q  <= wr;
        out_col_q  <= wc;
      end
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign out_valid = out_valid_q;
  assign out_row   = out_row_q;
  assign out_col   = out_col_q;
  assign out_data  = out_data_q;
  assign convOut   = conv_q;

endmodule

// File: tb/tb_conv2d_window_engine.sv
// Scoreboard bench for conv2d_window_engine: default instance plus a stride-2 instance.
module tb_conv2d_window_engine;

  typedef struct packed {
    int row;
    int col;
    int data;
  } exp_t;

  logic clock = 1'b0;
  logic nreset;
  logic start0, start1;
  logic signed [7:0] img [7][7];
  logic signed [7:0] ker [3][3];

  logic busy0, done0, valid0;
  logic [3:0] row0, col0;
  logic signed [7:0] data0;
  logic signed [7:0] conv0 [5][5];

  logic busy1, done1, valid1;
  logic [2:0] row1, col1;
  logic signed [7:0] data1;
  logic signed [7:0] conv1 [3][3];

  int checks = 0;
  int errors = 0;
  int pulses0 = 0;
  int pulses1 = 0;
  exp_t q0[$];
  exp_t q1[$];
  int cur_mode;  // 0: identity kernel on ramp image, 1: constant result
  int cur_cval;

  always #5 clock = ~clock;

  conv2d_window_engine dut (
    .clock(clock), .nreset(nreset), .start(start0), .inpMatrixI(img), .kernel(ker),
    .busy(busy0), .done(done0), .out_valid(valid0), .out_row(row0), .out_col(col0),
    .out_data(data0), .convOut(conv0)
  );

  conv2d_window_engine #(.STRIDE(2)) dut_s2 (
    .clock(clock), .nreset(nreset), .start(start1), .inpMatrixI(img), .kernel(ker),
    .busy(busy1), .done(done1), .out_valid(valid1), .out_row(row1), .out_col(col1),
    .out_data(data1), .convOut(conv1)
  );

  task automatic check(input string name, input logic signed [31:0] actual,
                       input logic signed [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, actual, expected);
    end
  endtask

  // Hand-derived expectations: identity kernel picks the window centre pixel r*7+c.
  function automatic int exp_val(input int inst, input int i, input int j);
    int s;
    s = (inst != 0) ? 2 : 1;
    if (cur_mode == 0) return (i * s + 1) * 7 + (j * s + 1);
    return cur_cval;
  endfunction

  function automatic int osz(input int inst);
    return (inst != 0) ? 3 : 5;
  endfunction

  function automatic logic get_busy(input int inst);
    return (inst != 0) ? busy1 : busy0;
  endfunction

  function automatic logic get_done(input int inst);
    return (inst != 0) ? done1 : done0;
  endfunction

  function automatic int conv_at(input int inst, input int i, input int j);
    return (inst != 0) ? int'(conv1[i][j]) : int'(conv0[i][j]);
  endfunction

  function automatic int conv_mismatches(input int inst);
    int n;
    n = 0;
    for (int i = 0; i < osz(inst); i++)
      for (int j = 0; j < osz(inst); j++)
        if (conv_at(inst, i, j) != exp_val(inst, i, j)) n++;
    return n;
  endfunction

  function automatic int conv_nonzero(input int inst);
    int n;
    n = 0;
    for (int i = 0; i < osz(inst); i++)
      for (int j = 0; j < osz(inst); j++)
        if (conv_at(inst, i, j) != 0) n++;
    return n;
  endfunction

  task automatic set_start(input int inst, input logic v);
    if (inst != 0) start1 = v;
    else           start0 = v;
  endtask

  task automatic set_image_ramp();
    for (int r = 0; r < 7; r++)
      for (int c = 0; c < 7; c++)
        img[r][c] = 8'(r * 7 + c);
  endtask

  task automatic set_image_const(input int v);
    for (int r = 0; r < 7; r++)
      for (int c = 0; c < 7; c++)
        img[r][c] = 8'(v);
  endtask

  task automatic set_kernel(input int centre, input int others);
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        ker[r][c] = (r == 1 && c == 1) ? 8'(centre) : 8'(others);
  endtask

  // Monitors: pop the scoreboard whenever an instance strobes a result.
  always @(negedge clock) begin
    exp_t e;
    if (valid0) begin
      pulses0++;
      check("i0_queue_nonempty", int'(q0.size() > 0), 1);
      if (q0.size() > 0) begin
        e = q0.pop_front();
        check("i0_out_row", row0, e.row);
        check("i0_out_col", col0, e.col);
        check("i0_out_data", data0, e.data);
      end
    end
  end

  always @(negedge clock) begin
    exp_t e;
    if (valid1) begin
      pulses1++;
      check("i1_queue_nonempty", int'(q1.size() > 0), 1);
      if (q1.size() > 0) begin
        e = q1.pop_front();
        check("i1_out_row", row1, e.row);
        check("i1_out_col", col1, e.col);
        check("i1_out_data", data1, e.data);
      end
    end
  end

  // One pass: push expectations, start, time done; optional mid-pass start pulse or reset.
  task automatic run_pass(input int inst, input int exp_done, input int glitch_at,
                          input int abort_at);
    int n;
    int done_at;
    int busy_gaps;
    int dones;
    exp_t e;
    for (int i = 0; i < osz(inst); i++)
      for (int j = 0; j < osz(inst); j++) begin
        e = '{row: i, col: j, data: exp_val(inst, i, j)};
        if (inst != 0) q1.push_back(e);
        else           q0.push_back(e);
      end
    if (inst != 0) pulses1 = 0;
    else           pulses0 = 0;
    @(negedge clock);
    set_start(inst, 1'b1);
    @(posedge clock);
    #1;
    set_start(inst, 1'b0);
    check("busy_after_accept", get_busy(inst), 1);
    n = 0;
    done_at = -1;
    busy_gaps = 0;
    while (n < 400 && done_at < 0) begin
      @(posedge clock);
      #1;
      n++;
      if (n == glitch_at)     set_start(inst, 1'b1);
      if (n == glitch_at + 1) set_start(inst, 1'b0);
      if (n == abort_at) begin
        nreset = 1'b0;
        #1;
        check("abort_busy", get_busy(inst), 0);
        check("abort_done", get_done(inst), 0);
        check("abort_out_valid", (inst != 0) ? valid1 : valid0, 0);
        check("abort_out_data", (inst != 0) ? data1 : data0, 0);
        check("abort_conv_nonzero", conv_nonzero(inst), 0);
        q0.delete();
        q1.delete();
        repeat (2) @(negedge clock);
        nreset = 1'b1;
        return;
      end
      if (get_done(inst)) done_at = n;
      else if (!get_busy(inst)) busy_gaps++;
    end
    check("done_cycle", done_at, exp_done);
    check("busy_continuous_gaps", busy_gaps, 0);
    check("busy_low_at_done", get_busy(inst), 0);
    dones = 1;
    repeat (15) begin
      @(posedge clock);
      #1;
      if (get_done(inst)) dones++;
    end
    check("done_pulse_count", dones, 1);
    check("idle_after_pass_busy", get_busy(inst), 0);
    check("out_valid_pulses", (inst != 0) ? pulses1 : pulses0, osz(inst) * osz(inst));
    check("queue_drained", (inst != 0) ? q1.size() : q0.size(), 0);
    check("convOut_mismatches", conv_mismatches(inst), 0);
  endtask

  initial begin
    nreset = 1'b0;
    start0 = 1'b0;
    start1 = 1'b0;
    set_image_ramp();
    set_kernel(1, 0);
    #12;
    check("reset_busy", busy0, 0);
    check("reset_done", done0, 0);
    check("reset_out_valid", valid0, 0);
    check("reset_out_row", row0, 0);
    check("reset_out_col", col0, 0);
    check("reset_out_data", data0, 0);
    check("reset_conv_nonzero", conv_nonzero(0), 0);
    check("reset_s2_busy", busy1, 0);
    @(negedge clock);
    nreset = 1'b1;

    // Identity kernel on ramp: convOut[i][j] = (i+1)*7+(j+1), [0][0]=8, [4][4]=40.
    cur_mode = 0;
    run_pass(0, 276, -10, -10);
    check("ident_conv_0_0", conv0[0][0], 8);
    check("ident_conv_4_4", conv0[4][4], 40);

    // All-ones kernel, constant images: 90, -180 -> -128, 127*127*9 -> 127.
    cur_mode = 1;
    set_kernel(1, 1);
    set_image_const(10);
    cur_cval = 90;
    run_pass(0, 276, -10, -10);
    set_image_const(-20);
    cur_cval = -128;
    run_pass(0, 276, -10, -10);
    set_kernel(127, 127);
    set_image_const(127);
    cur_cval = 127;
    run_pass(0, 276, -10, -10);

    // Stride 2: centre pixels at (2i+1, 2j+1), [1][1]=24, [2][2]=40.
    cur_mode = 0;
    set_image_ramp();
    set_kernel(1, 0);
    run_pass(1, 100, -10, -10);
    check("s2_conv_1_1", conv1[1][1], 24);
    check("s2_conv_2_2", conv1[2][2], 40);

    // Start pulsed again mid-pass must be ignored.
    run_pass(0, 276, 50, -10);

    // Reset mid-pass clears everything; a fresh pass then completes normally.
    run_pass(0, 276, -10, 120);
    run_pass(0, 276, -10, -10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
